// File: rtl/receiver.sv
// GMII receive path: frames are checked for FCS and length, then stored as a
// 7-word header (len, timestamp, received FCS) plus big-endian 16-bit payload.
module receiver #(
    parameter logic [15:0] MIN_LEN = 16'd60,
    parameter logic [15:0] MAX_LEN = 16'd1514
) (
    input  logic        gmii_rx_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] global_counter,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [15:0] slot_rx_eth_data,
    output logic [1:0]  slot_rx_eth_byte_en,
    output logic [15:0] slot_rx_eth_addr,
    output logic        slot_rx_eth_en,
    output logic        slot_rx_eth_wr_en,
    input  logic [15:0] mem_rd_ptr,
    output logic [15:0] mem_wr_ptr,
    output logic [15:0] rx_frame_cnt,
    output logic [15:0] rx_drop_cnt
);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_DATA,
        RX_HDR_WRITE,
        RX_DROP
    } state_t;

    state_t      state;
    logic [63:0] ts;
    logic [31:0] crc;
    logic [31:0] fcs_shift;
    logic [15:0] byte_cnt;
    logic [15:0] waddr;
    logic [15:0] frame_len;
    logic [15:0] commit_ptr;
    logic [7:0]  held;
    logic [2:0]  hdr_idx;
    logic        burst_seen;

    logic [31:0] crc_upd;
    logic [15:0] stop_addr;
    logic [15:0] hdr_room;
    logic [15:0] cnt_inc;
    logic [15:0] len_calc;
    logic        crc_ok;
    logic        len_ok;
    logic [15:0] hdr_word;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // The word just below the read pointer is never written, so a full ring
    // (wr+1 == rd) stays distinguishable from an empty one.
    assign stop_addr = mem_rd_ptr - 16'd1;
    assign hdr_room  = stop_addr - mem_wr_ptr;
    assign cnt_inc   = byte_cnt + 16'd1;
    assign len_calc  = byte_cnt - 16'd4;
    assign crc_upd   = crc_next(crc, gmii_rxd);
    // Residue C704DD7B in MSB-first notation reads DEBB20E3 in this LSB-first register.
    assign crc_ok    = (crc == 32'hDEBB20E3);
    assign len_ok    = (byte_cnt >= MIN_LEN + 16'd4) && (byte_cnt <= MAX_LEN + 16'd4);

    always_comb begin
        hdr_word = frame_len;
        case (hdr_idx)
            3'd1:    hdr_word = ts[63:48];
            3'd2:    hdr_word = ts[47:32];
            3'd3:    hdr_word = ts[31:16];
            3'd4:    hdr_word = ts[15:0];
            3'd5:    hdr_word = fcs_shift[31:16];
            3'd6:    hdr_word = fcs_shift[15:0];
            default: hdr_word = frame_len;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state               <= RX_IDLE;
            ts                  <= '0;
            crc                 <= '0;
            fcs_shift           <= '0;
            byte_cnt            <= '0;
            waddr               <= '0;
            frame_len           <= '0;
            commit_ptr          <= '0;
            held                <= '0;
            hdr_idx             <= '0;
            burst_seen          <= 1'b0;
            slot_rx_eth_data    <= '0;
            slot_rx_eth_byte_en <= '0;
            slot_rx_eth_addr    <= '0;
            slot_rx_eth_en      <= 1'b0;
            slot_rx_eth_wr_en   <= 1'b0;
            mem_wr_ptr          <= '0;
            rx_frame_cnt        <= '0;
            rx_drop_cnt         <= '0;
        end else begin
            slot_rx_eth_en    <= 1'b0;
            slot_rx_eth_wr_en <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == 8'h55) begin
                            state <= RX_PREAMBLE;
                        end else begin
                            rx_drop_cnt <= rx_drop_cnt + 16'd1;
                            state       <= RX_DROP;
                        end
                    end
                end
                RX_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state <= RX_DROP;
                    end else if (gmii_rxd == 8'hD5) begin
                        if (hdr_room < 16'd7) begin
                            rx_drop_cnt <= rx_drop_cnt + 16'd1;
                            state       <= RX_DROP;
                        end else begin
                            ts       <= global_counter;
                            crc      <= 32'hFFFFFFFF;
                            waddr    <= mem_wr_ptr + 16'd7;
                            byte_cnt <= '0;
                            state    <= RX_DATA;
                        end
                    end else if (gmii_rxd != 8'h55) begin
                        rx_drop_cnt <= rx_drop_cnt + 16'd1;
                        state       <= RX_DROP;
                    end
                end
                RX_DATA: begin
                    if (gmii_rx_dv) begin
                        crc       <= crc_upd;
                        byte_cnt  <= cnt_inc;
                        fcs_shift <= {fcs_shift[23:0], gmii_rxd};
                        if (gmii_rx_er || (cnt_inc > MAX_LEN + 16'd4)) begin
                            rx_drop_cnt <= rx_drop_cnt + 16'd1;
                            state       <= RX_DROP;
                        end else if (byte_cnt[0]) begin
                            if (waddr == stop_addr) begin
                                rx_drop_cnt <= rx_drop_cnt + 16'd1;
                                state       <= RX_DROP;
                            end else begin
                                slot_rx_eth_data    <= {held, gmii_rxd};
                                slot_rx_eth_byte_en <= 2'b11;
                                slot_rx_eth_addr    <= waddr;
                                slot_rx_eth_en      <= 1'b1;
                                slot_rx_eth_wr_en   <= 1'b1;
                                waddr               <= waddr + 16'd1;
                            end
                        end else begin
                            held <= gmii_rxd;
                        end
                    end else if (crc_ok && len_ok && !(byte_cnt[0] && (waddr == stop_addr))) begin
                        if (byte_cnt[0]) begin
                            slot_rx_eth_data    <= {held, 8'h00};
                            slot_rx_eth_byte_en <= 2'b10;
                            slot_rx_eth_addr    <= waddr;
                            slot_rx_eth_en      <= 1'b1;
                            slot_rx_eth_wr_en   <= 1'b1;
                        end
                        frame_len  <= len_calc;
                        commit_ptr <= mem_wr_ptr + 16'd7 + ((len_calc + 16'd1) >> 1);
                        hdr_idx    <= '0;
                        burst_seen <= 1'b0;
                        state      <= RX_HDR_WRITE;
                    end else begin
                        rx_drop_cnt <= rx_drop_cnt + 16'd1;
                        state       <= RX_IDLE;
                    end
                end
                RX_HDR_WRITE: begin
                    if (gmii_rx_dv) begin
                        burst_seen <= 1'b1;
                    end
                    if (hdr_idx != 3'd7) begin
                        slot_rx_eth_data    <= hdr_word;
                        slot_rx_eth_byte_en <= 2'b11;
                        slot_rx_eth_addr    <= mem_wr_ptr + {13'd0, hdr_idx};
                        slot_rx_eth_en      <= 1'b1;
                        slot_rx_eth_wr_en   <= 1'b1;
                        hdr_idx             <= hdr_idx + 3'd1;
                    end else begin
                        mem_wr_ptr   <= commit_ptr;
                        rx_frame_cnt <= rx_frame_cnt + 16'd1;
                        // A burst that started while the header was being written is discarded.
                        if (burst_seen || gmii_rx_dv) begin
                            rx_drop_cnt <= rx_drop_cnt + 16'd1;
                            state       <= gmii_rx_dv ? RX_DROP : RX_IDLE;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end
                end
                RX_DROP: begin
                    if (!gmii_rx_dv) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
GMII receive path, the counterpart of the TX sender.
- Captures frames arriving on gmii_rxd/gmii_rx_dv and timestamps each at SFD from global_counter.
- Checks the FCS and stores good frames in the RX frame slot memory in the same 7-word header + big-endian 16-bit payload layout the sender consumes.
- Commits each good frame by advancing mem_wr_ptr; bad frames are never committed.

Parameters:
MIN_LEN, 16'd60, minimum frame_len in bytes (excluding FCS); shorter frames are dropped.
MAX_LEN, 16'd1514, maximum frame_len in bytes (excluding FCS); longer frames are dropped.

Ports:
gmii_rx_clk  in  1  sole clock
sys_rst_n  in  1  reset, asynchronous, active-low
global_counter  in  64  free-running time base
gmii_rxd  in  8  GMII receive data
gmii_rx_dv  in  1  GMII data valid
gmii_rx_er  in  1  GMII receive error
slot_rx_eth_data  out  16  memory write data
slot_rx_eth_byte_en  out  2  byte enables; [1]=data[15:8], [0]=data[7:0]
slot_rx_eth_addr  out  16  memory word address
slot_rx_eth_en  out  1  memory enable (high exactly when wr_en high)
slot_rx_eth_wr_en  out  1  write strobe, 1-cycle pulses
mem_rd_ptr  in  16  consumer read pointer (word address)
mem_wr_ptr  out  16  committed write pointer (word address)
rx_frame_cnt  out  16  good frames committed, wraps
rx_drop_cnt  out  16  dropped frames, wraps

Behaviour:
- Reset (async): all outputs 0; state RX_IDLE; partial frame discarded; mem_wr_ptr=0.
- Storage layout, from base = mem_wr_ptr:
  - word 0: frame_len = bytes after SFD excluding the 4 FCS bytes.
  - words 1-4: timestamp[63:0], MSW first.
  - words 5-6: hash = received FCS value, i.e. the 4 FCS bytes in wire order with the first byte in [31:24].
  - payload from base+7: first byte in [15:8].
- RX_IDLE:
  - rx_dv=1 and rxd=8'h55 -> RX_PREAMBLE.
  - rx_dv=1 with any other byte -> RX_DROP.
- RX_PREAMBLE:
  - rxd=8'h55: stay.
  - rxd=8'hD5: latch ts=global_counter, init CRC to 32'hFFFFFFFF, waddr=base+7, byte count=0 -> RX_DATA.
  - Anything else, or rx_dv=0 -> RX_DROP (drop counted only if rx_dv still 1; preamble-only bursts are not counted).
- RX_DATA, per byte while rx_dv=1:
  - Update CRC-32 (poly 04C11DB7, reflected, LSB-first) and increment byte count.
  - Even-index byte: held in [15:8].
  - Odd-index byte: write word {held,byte}, byte_en=2'b11, waddr++ (16-bit wrap).
  - Before each write, if waddr == mem_rd_ptr-1 (mod 2^16) -> overflow -> RX_DROP.
  - rx_er=1 or byte count > MAX_LEN+4 -> RX_DROP.
  - rx_dv falling edge closes the frame. Good iff:
    - CRC residue = 32'hC704DD7B;
    - frame_len = count-4 is in [MIN_LEN, MAX_LEN];
    - no error occurred.
  - A trailing odd byte is written with byte_en=2'b10 in the cycle after rx_dv falls, and only if the frame is good.
  - Good -> RX_HDR_WRITE; bad -> rx_drop_cnt++ -> RX_IDLE.
- FCS bytes are written to memory as ordinary payload, but the commit pointer excludes them: commit = base + 7 + ceil(frame_len/2).
- RX_HDR_WRITE:
  - 7 consecutive cycles writing words 0..6 at base..base+6, byte_en=2'b11.
  - Next cycle: mem_wr_ptr <= commit, rx_frame_cnt++ -> RX_IDLE.
- Overflow check also covers the header: a frame is dropped if commit-1 would reach mem_rd_ptr (mod 2^16) i.e. the write pointer never catches the read pointer; full = (mem_wr_ptr+1 == mem_rd_ptr).
- RX_DROP: no memory writes; wait for rx_dv=0; increment rx_drop_cnt once on entry (except preamble-only case) -> RX_IDLE. mem_wr_ptr unchanged.
- If rx_dv rises during RX_HDR_WRITE, the header write completes; that arriving burst is treated via RX_DROP (counted).
- mem_wr_ptr changes only in a single cycle per good frame; it never passes mem_rd_ptr.
- Latency from last FCS byte to mem_wr_ptr update: ≤9 cycles.

Test Plan:
- 64-byte frame (60 payload + correct FCS), global_counter=64'h1234 at SFD, base 0 -> word0=16'd60, words1-4=0000,0000,0000,1234, payload at 7..36, mem_wr_ptr=37, rx_frame_cnt=1.
- 65-byte frame, frame_len=61 -> last payload word written with byte_en=2'b10, mem_wr_ptr=base+38.
- Same frame with one flipped payload bit -> no header written, mem_wr_ptr unchanged, rx_drop_cnt=1.
- rx_er pulse mid-frame, then a good frame -> drop counted, second frame committed at the same base.
- mem_rd_ptr=20, mem_wr_ptr=0, 64-byte frame -> overflow drop, mem_wr_ptr stays 0; then mem_rd_ptr=0 and resend -> committed.
- sys_rst_n low mid-frame -> all outputs 0 immediately; next frame stored at base 0.
